// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM:SS clock/timer blocks.
package clock_pkg;

   typedef enum logic [2:0] {
      CD_IDLE  = 3'd0,
      CD_SET   = 3'd1,
      CD_RUN   = 3'd2,
      CD_PAUSE = 3'd3,
      CD_DONE  = 3'd4
   } cd_state_t;

   localparam logic [7:0] SEC_MAX = 8'd59;
   localparam logic [7:0] MIN_MAX = 8'd59;

   localparam logic [1:0] FIELD_SEC  = 2'd0;
   localparam logic [1:0] FIELD_MIN  = 2'd1;
   localparam logic [1:0] FIELD_HOUR = 2'd2;
   localparam logic [1:0] FIELD_NONE = 2'd3;

   function automatic logic hms_is_zero(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
      return (s == 8'd0) && (m == 8'd0) && (h == 8'd0);
   endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Switch controls in, display/LED values out, for the countdown timer.
interface countdown_timer_if;

   logic       set_en;
   logic [1:0] field_sel;
   logic       inc_btn;
   logic       dec_btn;
   logic       start_btn;
   logic       clear_btn;
   logic [7:0] sec_out;
   logic [7:0] min_out;
   logic [7:0] hour_out;
   logic [2:0] state_out;
   logic       running;
   logic       alarm;

   modport master (
      output set_en, field_sel, inc_btn, dec_btn, start_btn, clear_btn,
      input  sec_out, min_out, hour_out, state_out, running, alarm
   );

   modport slave (
      input  set_en, field_sel, inc_btn, dec_btn, start_btn, clear_btn,
      output sec_out, min_out, hour_out, state_out, running, alarm
   );

endinterface

// File: rtl/countdown_timer_field_step.sv
// time_field_step: wrap-around +1/-1 of one time field; borrow_o flags a field at zero.
module time_field_step
   import clock_pkg::*;
#(
   parameter logic [7:0] MAX = SEC_MAX
) (
   input  logic [7:0] value_i,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [7:0] value_o,
   output logic       borrow_o
);

   // Simultaneous inc and dec cancel out.
   always_comb begin
      value_o = value_i;
      if (inc_i && !dec_i) begin
         if (value_i >= MAX) value_o = 8'd0;
         else                value_o = value_i + 8'd1;
      end else if (dec_i && !inc_i) begin
         if (value_i == 8'd0) value_o = MAX;
         else                 value_o = value_i - 8'd1;
      end else begin
         value_o = value_i;
      end
   end

   assign borrow_o = (value_i == 8'd0);

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer on the 1 Hz tick with preset, pause and alarm.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: reload preset on expiry instead of entering DONE.
module countdown_timer
   import clock_pkg::*;
#(
   parameter int HOUR_MAX  = 23,
   parameter int DONE_HOLD = 10
) (
   input logic              clk_1hz,
   input logic              rstb,
   countdown_timer_if.slave bus_if
);

   localparam logic [7:0] HOUR_MAX_B = 8'(HOUR_MAX);
   localparam logic [7:0] HOLD_LAST  = 8'(DONE_HOLD - 1);

   cd_state_t  state_q, state_d;
   logic [7:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
   logic [7:0] psec_q, psec_d, pmin_q, pmin_d, phour_q, phour_d;
   logic [7:0] hold_q, hold_d;
   logic       running_q, running_d, alarm_q, alarm_d;
   logic [3:0] btn_q, btn_s, ev_s;
   logic       clear_ev_s, start_ev_s, inc_ev_s, dec_ev_s;
   logic [2:0] sel_s;
   logic       edit_s, run_s, value_zero_s;
   logic [7:0] sec_step_s, min_step_s, hour_step_s;
   logic       sec_brw_s, min_brw_s, hour_brw_s;

   assign btn_s        = {bus_if.clear_btn, bus_if.start_btn, bus_if.dec_btn, bus_if.inc_btn};
   assign ev_s         = btn_s & ~btn_q;
   assign clear_ev_s   = ev_s[3];
   assign start_ev_s   = ev_s[2];
   assign dec_ev_s     = ev_s[1];
   assign inc_ev_s     = ev_s[0];
   assign edit_s       = (state_q == CD_SET);
   assign run_s        = (state_q == CD_RUN);
   assign value_zero_s = sec_brw_s & min_brw_s & hour_brw_s;

   always_comb begin
      sel_s = 3'b000;
      case (bus_if.field_sel)
         FIELD_SEC:  sel_s = 3'b001;
         FIELD_MIN:  sel_s = 3'b010;
         FIELD_HOUR: sel_s = 3'b100;
         FIELD_NONE: sel_s = 3'b000;
         default:    sel_s = 3'b000;
      endcase
   end

   // The same steppers serve SET editing and the RUN borrow chain.
   time_field_step #(.MAX(SEC_MAX)) u_sec (
      .value_i  (sec_q),
      .inc_i    (edit_s & sel_s[0] & inc_ev_s),
      .dec_i    ((edit_s & sel_s[0] & dec_ev_s) | run_s),
      .value_o  (sec_step_s),
      .borrow_o (sec_brw_s)
   );

   time_field_step #(.MAX(MIN_MAX)) u_min (
      .value_i  (min_q),
      .inc_i    (edit_s & sel_s[1] & inc_ev_s),
      .dec_i    ((edit_s & sel_s[1] & dec_ev_s) | (run_s & sec_brw_s)),
      .value_o  (min_step_s),
      .borrow_o (min_brw_s)
   );

   time_field_step #(.MAX(HOUR_MAX_B)) u_hour (
      .value_i  (hour_q),
      .inc_i    (edit_s & sel_s[2] & inc_ev_s),
      .dec_i    ((edit_s & sel_s[2] & dec_ev_s) | (run_s & sec_brw_s & min_brw_s)),
      .value_o  (hour_step_s),
      .borrow_o (hour_brw_s)
   );

   always_comb begin
      state_d   = state_q;
      sec_d     = sec_q;
      min_d     = min_q;
      hour_d    = hour_q;
      psec_d    = psec_q;
      pmin_d    = pmin_q;
      phour_d   = phour_q;
      hold_d    = hold_q;
      alarm_d   = 1'b0;
      running_d = 1'b0;
      if (clear_ev_s) begin
         state_d = CD_IDLE;
         sec_d   = 8'd0;
         min_d   = 8'd0;
         hour_d  = 8'd0;
         psec_d  = 8'd0;
         pmin_d  = 8'd0;
         phour_d = 8'd0;
         hold_d  = 8'd0;
      end else begin
         case (state_q)
            CD_IDLE, CD_SET: begin
               if ((state_q == CD_IDLE) && bus_if.set_en) begin
                  state_d = CD_SET;
               end else if ((state_q == CD_SET) && !bus_if.set_en) begin
                  state_d = CD_IDLE;
               end else if (start_ev_s && !value_zero_s) begin
                  psec_d  = sec_q;
                  pmin_d  = min_q;
                  phour_d = hour_q;
                  state_d = CD_RUN;
               end else if (state_q == CD_SET) begin
                  sec_d  = sec_step_s;
                  min_d  = min_step_s;
                  hour_d = hour_step_s;
               end else begin
                  state_d = CD_IDLE;
               end
            end
            CD_RUN: begin
               if (start_ev_s) begin
                  state_d = CD_PAUSE;
               end else if (value_zero_s) begin
                  state_d = CD_IDLE;
               end else if (hms_is_zero(sec_step_s, min_step_s, hour_step_s)) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  sec_d   = psec_q;
                  min_d   = pmin_q;
                  hour_d  = phour_q;
                  alarm_d = 1'b1;
`else
                  sec_d   = sec_step_s;
                  min_d   = min_step_s;
                  hour_d  = hour_step_s;
                  hold_d  = 8'd0;
                  state_d = CD_DONE;
`endif
               end else begin
                  sec_d  = sec_step_s;
                  min_d  = min_step_s;
                  hour_d = hour_step_s;
               end
            end
            CD_PAUSE: begin
               if (bus_if.set_en)   state_d = CD_SET;
               else if (start_ev_s) state_d = CD_RUN;
               else                 state_d = CD_PAUSE;
            end
            CD_DONE: begin
               if (start_ev_s || inc_ev_s || dec_ev_s || (hold_q == HOLD_LAST)) begin
                  state_d = CD_IDLE;
                  sec_d   = psec_q;
                  min_d   = pmin_q;
                  hour_d  = phour_q;
               end else begin
                  hold_d = hold_q + 8'd1;
               end
            end
            default: begin
               state_d = CD_IDLE;
               hold_d  = 8'd0;
            end
         endcase
      end
      running_d = (state_d == CD_RUN);
      alarm_d   = alarm_d | (state_d == CD_DONE);
   end

   always_ff @(posedge clk_1hz or negedge rstb) begin
      if (!rstb) begin
         state_q   <= CD_IDLE;
         sec_q     <= 8'd0;
         min_q     <= 8'd0;
         hour_q    <= 8'd0;
         psec_q    <= 8'd0;
         pmin_q    <= 8'd0;
         phour_q   <= 8'd0;
         hold_q    <= 8'd0;
         running_q <= 1'b0;
         alarm_q   <= 1'b0;
         btn_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         sec_q     <= sec_d;
         min_q     <= min_d;
         hour_q    <= hour_d;
         psec_q    <= psec_d;
         pmin_q    <= pmin_d;
         phour_q   <= phour_d;
         hold_q    <= hold_d;
         running_q <= running_d;
         alarm_q   <= alarm_d;
         btn_q     <= btn_s;
      end
   end

   assign bus_if.sec_out   = sec_q;
   assign bus_if.min_out   = min_q;
   assign bus_if.hour_out  = hour_q;
   assign bus_if.state_out = state_q;
   assign bus_if.running   = running_q;
   assign bus_if.alarm     = alarm_q;

endmodule
